// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand sequencer for the 4x4 systolic_array. Matrices A and B live in two
//   16-entry register files loaded through a simple write port. A start pulse
//   clears the array, streams the diagonally skewed operands into the west and
//   north edges, waits for the array's done and then pulses complete.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_sel        operand write strobe / target (0 = A, 1 = B), IDLE only
//   wr_addr/wr_data     element index row*4+col / element value
//   start               begin a run (sampled in IDLE only)
//   array_done          done from the array (sampled in DRAIN only)
//   array_clr           one-cycle clear pulse to the array
//   west0/4/8/12        row operands to the array's input_west*
//   north0..north3      column operands to the array's input_north*
//   busy                run in progress
//   complete            one-cycle pulse when a run finishes
module systolic_feeder #(
    parameter int DATA_BIT = 8,
    parameter int N        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [3:0]          wr_addr,
    input  logic [DATA_BIT-1:0] wr_data,
    input  logic                start,
    input  logic                array_done,
    output logic                array_clr,
    output logic [DATA_BIT-1:0] west0,
    output logic [DATA_BIT-1:0] west4,
    output logic [DATA_BIT-1:0] west8,
    output logic [DATA_BIT-1:0] west12,
    output logic [DATA_BIT-1:0] north0,
    output logic [DATA_BIT-1:0] north1,
    output logic [DATA_BIT-1:0] north2,
    output logic [DATA_BIT-1:0] north3,
    output logic                busy,
    output logic                complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          t_q;
    logic [2:0]          t_d;
    logic                clr_q;
    logic                busy_q;
    logic                complete_q;
    logic [DATA_BIT-1:0] a_q     [N*N];
    logic [DATA_BIT-1:0] b_q     [N*N];
    logic [DATA_BIT-1:0] west_q  [N];
    logic [DATA_BIT-1:0] north_q [N];
    logic [DATA_BIT-1:0] west_d  [N];
    logic [DATA_BIT-1:0] north_d [N];

    // Lane values for the feed step that becomes visible after the coming
    // edge: step 0 when leaving CLEAR, otherwise the step after t_q.
    always_comb begin
        logic signed [3:0] diff;
        diff = '0;
        t_d  = (state_q == S_CLEAR) ? 3'd0 : t_q + 3'd1;
        for (int r = 0; r < N; r++) begin
            // Lane r/c is skewed by its index; out-of-window steps feed 0.
            diff       = $signed({1'b0, t_d}) - $signed(4'(r));
            west_d[r]  = '0;
            north_d[r] = '0;
            if (diff >= 4'sd0 && diff <= 4'sd3) begin
                west_d[r]  = a_q[{2'(r), diff[1:0]}];
                north_d[r] = b_q[{diff[1:0], 2'(r)}];
            end
        end
    end

    // Operand storage; writes are accepted only while idle. A write that
    // coincides with start lands on the edge that enters CLEAR, so the run
    // already sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (wr_en && state_q == S_IDLE) begin
            if (wr_sel) b_q[wr_addr] <= wr_data;
            else        a_q[wr_addr] <= wr_data;
        end
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            west_q     <= '{default: '0};
            north_q    <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_FEED;
                    clr_q   <= 1'b0;
                    t_q     <= t_d;
                    west_q  <= west_d;
                    north_q <= north_d;
                end
                S_FEED: begin
                    // t_q is the step currently on the lanes; 2N-1 steps total.
                    if (t_q == 3'd6) begin
                        state_q <= S_DRAIN;
                        west_q  <= '{default: '0};
                        north_q <= '{default: '0};
                    end else begin
                        t_q     <= t_d;
                        west_q  <= west_d;
                        north_q <= north_d;
                    end
                end
                S_DRAIN: begin
                    if (array_done) begin
                        state_q    <= S_DONE;
                        complete_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    complete_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign array_clr = clr_q;
    assign busy      = busy_q;
    assign complete  = complete_q;
    assign west0     = west_q[0];
    assign west4     = west_q[1];
    assign west8     = west_q[2];
    assign west12    = west_q[3];
    assign north0    = north_q[0];
    assign north1    = north_q[1];
    assign north2    = north_q[2];
    assign north3    = north_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, wr_sel, start, array_done;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       array_clr, busy, complete;
    logic [7:0] west0, west4, west8, west12;
    logic [7:0] north0, north1, north2, north3;

    systolic_feeder #(.DATA_BIT(8), .N(4)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .array_done(array_done), .array_clr(array_clr),
        .west0(west0), .west4(west4), .west8(west8), .west12(west12),
        .north0(north0), .north1(north1), .north2(north2), .north3(north3),
        .busy(busy), .complete(complete)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference operand matrices, updated only by accepted writes.
    logic [7:0] ma [16];
    logic [7:0] mb [16];

    // Scoreboard of expected {array_clr, busy, complete, west0..12, north0..3}.
    logic [66:0] exp_q [$];

    // Lane captures of the most recent run, indexed by feed step.
    logic [7:0] cap_w0 [7];
    logic [7:0] cap_w12[7];
    logic [7:0] cap_n0 [7];
    logic [7:0] cap_n3 [7];

    function automatic logic [66:0] obs_vec();
        return {array_clr, busy, complete, west0, west4, west8, west12,
                north0, north1, north2, north3};
    endfunction

    // Expected lane vector for feed step t from the reference matrices.
    function automatic logic [66:0] feed_vec(int t);
        logic [7:0] w [4];
        logic [7:0] n [4];
        for (int k = 0; k < 4; k++) begin
            w[k] = 8'd0;
            n[k] = 8'd0;
            if (t >= k && t - k <= 3) begin
                w[k] = ma[k*4 + (t - k)];
                n[k] = mb[(t - k)*4 + k];
            end
        end
        return {1'b0, 1'b1, 1'b0, w[0], w[1], w[2], w[3], n[0], n[1], n[2], n[3]};
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one edge, then pop the scoreboard and compare.
    task automatic step_check(input string tag);
        logic [66:0] e;
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs_vec());
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs_vec(), e);
        end
    endtask

    task automatic write_op(input logic sel, input int addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    // One complete run. Called 1 time unit after a rising edge.
    task automatic do_run(input int drain_wait, input bit inject,
                          input bit wr_with_start, input logic [7:0] wdata);
        start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = wdata;
            mb[0] = wdata;
        end
        exp_q.push_back({1'b1, 1'b1, 1'b0, 64'd0});
        for (int t = 0; t < 7; t++) exp_q.push_back(feed_vec(t));
        exp_q.push_back({1'b0, 1'b1, 1'b0, 64'd0});

        step_check("clear");
        start = 1'b0;
        wr_en = 1'b0;
        for (int t = 0; t < 7; t++) begin
            step_check($sformatf("feed_t%0d", t));
            cap_w0[t]  = west0;
            cap_w12[t] = west12;
            cap_n0[t]  = north0;
            cap_n3[t]  = north3;
            if (inject && t == 2) begin
                start = 1'b1; array_done = 1'b1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
            end else if (inject && t == 3) begin
                start = 1'b0; array_done = 1'b0; wr_en = 1'b0;
            end
        end
        step_check("lanes_zero_k8");
        for (int i = 0; i < drain_wait; i++) begin
            exp_q.push_back({1'b0, 1'b1, 1'b0, 64'd0});
            step_check($sformatf("drain_%0d", i));
        end
        array_done = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 64'd0});
        step_check("complete");
        array_done = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 64'd0});
        step_check("idle_after");
    endtask

    initial begin
        automatic logic [7:0] ew0  [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0};
        automatic logic [7:0] ew12 [7] = '{8'd0, 8'd0, 8'd0, 8'd13, 8'd14, 8'd15, 8'd16};
        automatic logic [7:0] en3  [7] = '{8'd0, 8'd0, 8'd0, 8'd19, 8'd23, 8'd27, 8'd31};

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; array_done = 1'b0;
        for (int i = 0; i < 16; i++) begin ma[i] = 8'd0; mb[i] = 8'd0; end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs_vec(), 67'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Skew pattern, minimum-latency completion
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                write_op(1'b0, i*4 + j, 8'(4*i + j + 1));
                write_op(1'b1, i*4 + j, 8'(16 + 4*i + j));
            end
        do_run(0, 1'b0, 1'b0, 8'd0);
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("skew_west0_t%0d", t),  {59'd0, cap_w0[t]},  {59'd0, ew0[t]});
            chk($sformatf("skew_west12_t%0d", t), {59'd0, cap_w12[t]}, {59'd0, ew12[t]});
            chk($sformatf("skew_north3_t%0d", t), {59'd0, cap_n3[t]},  {59'd0, en3[t]});
        end

        // Ignored start/write/done during FEED, then a long DRAIN wait
        do_run(20, 1'b1, 1'b0, 8'd0);

        // The ignored write must not have reached A[0][0]
        do_run(2, 1'b0, 1'b0, 8'd0);
        chk("a00_kept", {59'd0, cap_w0[0]}, {59'd0, 8'd1});

        // Write together with start is used by the same run
        do_run(1, 1'b0, 1'b1, 8'd200);
        chk("wr_with_start_north0", {59'd0, cap_n0[0]}, {59'd0, 8'd200});

        // Asynchronous reset mid-FEED
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_feed", {66'd0, busy}, {66'd0, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", obs_vec(), 67'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin ma[i] = 8'd0; mb[i] = 8'd0; end
        @(posedge clk); #1;
        do_run(0, 1'b0, 1'b0, 8'd0);
        chk("post_reset_zero_west0", {59'd0, cap_w0[0]}, {59'd0, 8'd0});

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer that drives the west and north edges of the 4x4 `systolic_array`. It holds matrices A and B in a small register file loaded through a write port. On `start` it clears the array and emits the diagonally skewed operand streams, one element per lane per cycle. It then waits for the array's `done` and reports completion, so software only has to load the operands and start the block.

## Interface
- `DATA_BIT`, 8, operand width. It matches the array's `DATA_BIT`.
- `N`, 4, array dimension. It is fixed at 4; other values are unsupported.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  operand write strobe
- `wr_sel`  in  1  write target: 0 = A, 1 = B
- `wr_addr`  in  4  element index, row*4+col
- `wr_data`  in  DATA_BIT  element value
- `start`  in  1  begin a run; sampled in IDLE only
- `array_done`  in  1  `done` from `systolic_array`
- `array_clr`  out  1  one-cycle clear pulse to the array's `rst`
- `west0`, `west4`, `west8`, `west12`  out  DATA_BIT each  operands to the array's `input_west*`
- `north0`..`north3`  out  DATA_BIT each  operands to the array's `input_north*`
- `busy`  out  1  run in progress
- `complete`  out  1  one-cycle pulse when a run finishes

One clock; reset is asynchronous and active-high (`clk`, `rst`).

## Operation
- Storage is two 16-entry register files, A and B. Reset clears every entry to 0.
- Writes:
  - `wr_en` in IDLE writes `wr_data` into A or B at `wr_addr`, taking effect on the next edge.
  - `wr_en` while `busy` is ignored; storage is unchanged.
- FSM has five states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE -> CLEAR when `start`=1.
  - CLEAR -> FEED unconditionally. `array_clr`=1 for this cycle only. The feed counter `t` is reset to 0.
  - FEED runs for `t` = 0..6 (2N-1 cycles).
    - West lane r (`west0`/`west4`/`west8`/`west12` for r=0..3) outputs A[r][t-r] when 0 <= t-r <= 3, else 0.
    - North lane c outputs B[t-c][c] when 0 <= t-c <= 3, else 0.
    - After `t`=6 -> DRAIN.
  - DRAIN holds all lanes at 0. `array_done`=1 -> DONE. There is no timeout.
  - DONE raises `complete` for one cycle, then -> IDLE.
- `busy`=1 in CLEAR, FEED, DRAIN and DONE.
- `start` outside IDLE is ignored; it is not queued.
- `start` and `wr_en` together in IDLE: the write is performed, and the run uses the updated value. The write lands on the same edge the FSM enters CLEAR, before any read.
- `array_done` seen in CLEAR or FEED is ignored; only DRAIN samples it.
- Arithmetic: unsigned operands. Index logic uses `t` (3 bits) and `t-r`/`t-c` compared as signed 4-bit values.

## Timing
- All outputs are registered.
- Reset values: lanes 0, `array_clr` 0, `busy` 0, `complete` 0, state IDLE, `t`=0.
- Asserting `rst` mid-run forces reset values immediately (asynchronously). The next run needs a fresh `start`, with operands reloaded, since storage is cleared.
- With `start` sampled at edge k:
  - `busy` and `array_clr` are high after edge k.
  - `array_clr` is low after edge k+1.
  - Lane values for `t` are visible after edge k+1+t, so first operands appear after k+1 and the last after k+7.
  - Lanes are 0 after edge k+8.
- With `array_done` sampled high in DRAIN at edge m: `complete`=1 after edge m and `busy`=0 after edge m+1.
- Minimum start-to-`complete` latency is 9 cycles, reached when `array_done` is already high on entry to DRAIN.
- Back-to-back runs: `start` is accepted on the first cycle after DONE, i.e. in IDLE.

## Test plan
- **Reset check:** hold `rst`=1 mid-FEED -> every output is 0 and `busy`=0 without waiting for a clock edge. Release, then pulse `start` -> lanes still stream zeros, because storage was cleared.
- **Skew pattern:** load A[i][j]=4i+j+1 and B[i][j]=16+4i+j, then pulse `start`.
  - After edges k+1..k+7, `west0` shows 1,2,3,4,0,0,0.
  - `west12` shows 0,0,0,13,14,15,16.
  - `north3` shows 0,0,0,19,23,27,31.
  - `array_clr` is high for exactly one cycle, the one after edge k.
- **End-to-end:** connect to `systolic_array` with A=identity and B as above -> after `complete`, `result0`..`result15` equal 16..31.
- **Ignored inputs:**
  - `start` during FEED -> no restart; `t` continues.
  - `wr_en` (A[0][0]=99) during FEED -> A[0][0] is still 1 on the next run.
  - `array_done` pulsed during FEED -> no early `complete`.
- **DRAIN wait:** hold `array_done`=0 for 20 cycles after FEED -> `busy` stays 1 and lanes stay 0. Raise it -> `complete` pulses one cycle, then `busy` drops.
- **Write with start:** `start` together with `wr_en`, sel=B, addr=0, data=200 -> `north0` shows 200 after edge k+1.
